// File: rtl/sipo_frame_pkg.sv
// Shared definitions for the framed serial-in/parallel-out receiver:
// FSM state encoding, frame bit levels and a counter-width helper.
package sipo_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bits needed to count 0..v-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Parallel output buffer handshake of the frame receiver.
//   dout       : received word
//   dout_valid : buffer holds an unconsumed word
//   dout_ready : consumer accepts dout this cycle
// master = receiver side, slave = consumer side.
interface sipo_frame_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/sipo_shifter.sv
// WIDTH-bit shift register, serial input enters at the LSB.
//   clk, reset_n : clock, async active-low reset
//   en           : shift enable
//   sdi          : serial input
//   q            : parallel contents
module sipo_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sdi,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], sdi};
        end
    end
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start bit (1), WIDTH data bits MSB first, stop bit (0).
// Bits are taken only on sen strobes; completed words go to a valid/ready buffer.
//   clk, reset_n    : clock, async active-low reset
//   sdi, sen        : serial data and bit strobe
//   bus (master)    : dout / dout_valid / dout_ready output buffer
//   busy            : frame reception in progress
//   frame_err       : one-cycle pulse, stop bit sampled as 1
//   overrun         : one-cycle pulse, completed word dropped (buffer full)
module sipo_frame_ctrl
    import sipo_frame_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sdi,
    input  logic               sen,
    sipo_frame_ctrl_if.master  bus,
    output logic               busy,
    output logic               frame_err,
    output logic               overrun
);
    localparam int unsigned CW = clog2(WIDTH);

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] dout_d;
    logic             valid_d;
    logic             ferr_d;
    logic             ovr_d;
    logic             shift_en;

    sipo_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (shift_en),
        .sdi     (sdi),
        .q       (word)
    );

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            busy           <= 1'b0;
            frame_err      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            bus.dout       <= dout_d;
            bus.dout_valid <= valid_d;
            busy           <= (state_d != IDLE);
            frame_err      <= ferr_d;
            overrun        <= ovr_d;
        end
    end

    // Next-state, shift control and buffer load/handshake.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        dout_d   = bus.dout;
        valid_d  = bus.dout_valid;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        shift_en = 1'b0;

        // A pop empties the buffer unless a load below refills it.
        if (bus.dout_valid && bus.dout_ready) begin
            valid_d = 1'b0;
        end

        case (state)
            IDLE: begin
                if (sen && (sdi == START_BIT)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (sen) begin
                    shift_en = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            STOP: begin
                // Stop bit is consumed here and never reused as a start bit.
                if (sen) begin
                    state_d = IDLE;
                    if (sdi == STOP_BIT) begin
                        if (!bus.dout_valid || bus.dout_ready) begin
                            dout_d  = word;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Controller that sequences a serial-in/parallel-out shift register to receive framed serial words. A frame is one start bit (1), WIDTH data bits (MSB first) and one stop bit (0).
- Bits are taken only on cycles where the bit strobe sen is high.
- Each completed word is presented on a valid/ready parallel output buffer.
- Framing errors and overruns are flagged.
- Sits between a serial pin/sampler stage and a parallel consumer.

Parameters:
WIDTH, 8, data bits per frame (2..32)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
sdi  input  1  serial data in, already synchronous to clk
sen  input  1  bit strobe; sdi is sampled only when sen=1
dout  output  WIDTH  received word (valid when dout_valid=1)
dout_valid  output  1  output buffer holds an unconsumed word
dout_ready  input  1  consumer accepts dout this cycle
busy  output  1  frame reception in progress (state != IDLE)
frame_err  output  1  one-cycle pulse: stop bit sampled as 1
overrun  output  1  one-cycle pulse: completed word dropped, buffer full

Behaviour:
- Reset (async, reset_n=0): state=IDLE, shift reg=0, bit counter=0, dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0. Reset mid-frame abandons the partial word; the buffered word is lost.
- FSM states: IDLE, SHIFT, STOP. All transitions occur only on edges where sen=1, except buffer handshake and pulse clearing.
- IDLE: sen=1 && sdi=1 (start bit) -> SHIFT, counter=0. sen=1 && sdi=0 -> stay IDLE.
- SHIFT: each sen=1 edge shifts sdi into the LSB, register <= {reg[WIDTH-2:0], sdi}, and increments the counter.
  - When the counter reaches WIDTH-1 on a sen edge (WIDTH-th bit taken) -> STOP.
  - The first data bit ends in dout[WIDTH-1].
- STOP, on a sen=1 edge:
  - sdi=0: word complete -> IDLE and attempt load.
  - sdi=1: frame_err=1 for one cycle, word discarded -> IDLE. The stop-bit 1 is NOT reused as a new start bit.
- Load rules, evaluated at the completing edge:
  - dout_valid=0: dout<=word, dout_valid<=1.
  - dout_valid=1 && dout_ready=1 (same-cycle pop): dout<=new word, dout_valid stays 1. Not an overrun.
  - dout_valid=1 && dout_ready=0: new word dropped, dout unchanged, overrun=1 for one cycle.
- Handshake:
  - Transfer occurs on an edge where dout_valid && dout_ready; with no load that edge, dout_valid<=0 and dout holds its last value.
  - dout is stable while dout_valid=1 and dout_ready=0.
  - dout_ready while dout_valid=0 is ignored.
- Latency: dout_valid rises the cycle after the clock edge that samples a good stop bit. A minimum frame is WIDTH+2 sen strobes.
- sen=0 cycles freeze state, counter and shift register. Arbitrary gaps between strobes are legal.
- busy = (state != IDLE), registered with state.
- frame_err and overrun are registered one-cycle pulses. They cannot both fire on the same edge.

Decomposition:
- Package sipo_frame_pkg:
  - state encoding IDLE=2'd0, SHIFT=2'd1, STOP=2'd2;
  - START_BIT=1'b1, STOP_BIT=1'b0;
  - counter-width function clog2(WIDTH).
- Sub-module sipo_shifter: WIDTH-bit shift register with async active-low reset, shift enable and serial input, q output. The controller drives its enable (sen && state==SHIFT) and captures q at stop.

Test Plan:
1. WIDTH=8, reset then dout_ready=1, sen=1 every cycle, sdi=1,10100101,0 -> dout=8'hA5, dout_valid high exactly 1 cycle, frame_err=0, overrun=0, busy high for 9 cycles.
2. Same frame with sen=1 only every 3rd cycle, dout_ready=0 -> dout=8'hA5 held with dout_valid=1 until ready raised, then dout_valid=0 next edge.
3. Stop bit sent as 1 (sdi=1,11110000,1) -> frame_err pulses 1 cycle, dout_valid stays 0, FSM back to IDLE; the next valid frame 0x3C is received correctly.
4. dout_ready=0: frames 0x11 then 0x22 -> dout=8'h11, overrun pulses once at the 0x22 stop edge. Repeat with dout_ready=1 on the exact completing edge of 0x22 -> dout=8'h22, dout_valid stays 1, no overrun.
5. reset_n=0 asserted asynchronously (between clk edges) after 4 data bits of a frame -> all outputs 0 immediately. After release, a clean frame 0xC3 is received as 8'hC3 with no stale bits.
6. Idle line sdi=0 with sen toggling for 20 cycles -> busy=0, dout_valid=0, no pulses.
